// File: rtl/fifo_wr_arbiter_if.sv
// Requester and FIFO write-port bundle shared by the write-side arbiter.
// The master modport is the arbiter; the slave modport is its environment
// (the requesters plus the FIFO write port).
interface fifo_wr_arbiter_if #(
  parameter int DSIZE = 8,
  parameter int ASIZE = 10,
  parameter int NREQ  = 4
);
  logic [NREQ-1:0]       req_valid;
  logic [NREQ*DSIZE-1:0] req_data;
  logic [NREQ-1:0]       req_last;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ-1:0]       grant;
  logic                  busy;
  logic [DSIZE-1:0]      wdata;
  logic                  w_en;
  logic                  w_full;
  logic [ASIZE-1:0]      wuse;

  modport master (
    input  req_valid, req_data, req_last, w_full, wuse,
    output req_ready, grant, busy, wdata, w_en
  );

  modport slave (
    output req_valid, req_data, req_last, w_full, wuse,
    input  req_ready, grant, busy, wdata, w_en
  );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin, burst-granular write scheduler for the shared stream FIFO.
// A grant is only issued while the FIFO reports room (wuse below AF_LEVEL);
// once granted, a burst runs until the requester's last beat or MAX_BURST
// beats, with every beat gated by w_full. One IDLE cycle separates bursts.
module fifo_wr_arbiter #(
  parameter int DSIZE     = 8,
  parameter int ASIZE     = 10,
  parameter int NREQ      = 4,
  parameter int MAX_BURST = 16,
  parameter int AF_LEVEL  = 1000
) (
  input  logic               wclk,
  input  logic               rst_n,
  fifo_wr_arbiter_if.master  bus
);

  localparam int IDX_W = $clog2(NREQ);
  localparam int CNT_W = $clog2(MAX_BURST + 1);

  localparam logic [IDX_W:0]   NREQ_W     = (IDX_W + 1)'(NREQ);
  localparam logic [IDX_W-1:0] PTR_RST    = IDX_W'(NREQ - 1);
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(MAX_BURST - 1);
  localparam logic [31:0]      AF_LEVEL_U = AF_LEVEL;

  typedef enum logic {IDLE = 1'b0, XFER = 1'b1} state_t;

  state_t           state, state_nxt;
  logic [NREQ-1:0]  grant, grant_nxt;
  logic             busy, busy_nxt;
  logic [IDX_W-1:0] gidx, gidx_nxt;
  logic [IDX_W-1:0] last_ptr, last_ptr_nxt;
  logic [CNT_W-1:0] beat_cnt, beat_cnt_nxt;

  logic [IDX_W-1:0] sel_idx;
  logic             sel_found;
  logic             room;
  logic             beat;
  logic             burst_end;
  logic [NREQ-1:0]  ready;
  logic [DSIZE-1:0] wdata;
  logic             w_en;

  // wuse is an overestimate that lags the FIFO, so this admission test is conservative
  assign room = (32'(bus.wuse) < AF_LEVEL_U);

  // Round-robin pick: scan last_ptr+1 .. last_ptr+NREQ downwards so the nearest valid requester wins
  always_comb begin
    logic [IDX_W:0]   sum;
    logic [IDX_W-1:0] idx;
    sel_found = 1'b0;
    sel_idx   = '0;
    sum       = '0;
    idx       = '0;
    for (int k = NREQ; k >= 1; k--) begin
      sum = {1'b0, last_ptr} + (IDX_W + 1)'(k);
      if (sum >= NREQ_W) sum = sum - NREQ_W;
      idx = sum[IDX_W-1:0];
      if (bus.req_valid[idx]) begin
        sel_found = 1'b1;
        sel_idx   = idx;
      end
    end
  end

  // Datapath and handshake for the granted requester; everything is forced quiet while in reset
  always_comb begin
    ready     = '0;
    wdata     = '0;
    beat      = 1'b0;
    burst_end = 1'b0;
    if (rst_n && state == XFER) begin
      ready = grant & {NREQ{~bus.w_full}};
      for (int i = 0; i < NREQ; i++) begin
        if (gidx == IDX_W'(i)) wdata = bus.req_data[i*DSIZE +: DSIZE];
      end
      beat      = bus.req_valid[gidx] & ~bus.w_full;
      burst_end = beat & (bus.req_last[gidx] | (beat_cnt == CNT_LAST));
    end
    w_en = beat;
  end

  // Next-state logic: grant on room+request, release on last beat or burst limit, hold otherwise
  always_comb begin
    state_nxt    = state;
    grant_nxt    = grant;
    busy_nxt     = busy;
    gidx_nxt     = gidx;
    last_ptr_nxt = last_ptr;
    beat_cnt_nxt = beat_cnt;
    unique case (state)
      IDLE: begin
        if (sel_found && room) begin
          state_nxt    = XFER;
          grant_nxt    = {{(NREQ-1){1'b0}}, 1'b1} << sel_idx;
          busy_nxt     = 1'b1;
          gidx_nxt     = sel_idx;
          beat_cnt_nxt = '0;
        end
      end
      XFER: begin
        if (burst_end) begin
          state_nxt    = IDLE;
          grant_nxt    = '0;
          busy_nxt     = 1'b0;
          last_ptr_nxt = gidx;
          beat_cnt_nxt = '0;
        end else if (beat) begin
          beat_cnt_nxt = beat_cnt + 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
        grant_nxt = '0;
        busy_nxt  = 1'b0;
      end
    endcase
  end

  // State register with synchronous active-low reset
  always_ff @(posedge wclk) begin
    if (!rst_n) begin
      state    <= IDLE;
      grant    <= '0;
      busy     <= 1'b0;
      gidx     <= '0;
      last_ptr <= PTR_RST;
      beat_cnt <= '0;
    end else begin
      state    <= state_nxt;
      grant    <= grant_nxt;
      busy     <= busy_nxt;
      gidx     <= gidx_nxt;
      last_ptr <= last_ptr_nxt;
      beat_cnt <= beat_cnt_nxt;
    end
  end

  assign bus.req_ready = ready;
  assign bus.grant     = grant;
  assign bus.busy      = busy;
  assign bus.wdata     = wdata;
  assign bus.w_en      = w_en;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: directed scenarios followed by a randomized run,
// every cycle compared against a transaction-level model of the arbiter.
module tb_fifo_wr_arbiter;
  localparam int DSIZE     = 8;
  localparam int ASIZE     = 10;
  localparam int NREQ      = 4;
  localparam int MAX_BURST = 16;
  localparam int AF_LEVEL  = 1000;

  logic wclk = 1'b0;
  logic rst_n;
  always #5 wclk = ~wclk;

  fifo_wr_arbiter_if #(.DSIZE(DSIZE), .ASIZE(ASIZE), .NREQ(NREQ)) bus ();

  fifo_wr_arbiter #(
    .DSIZE(DSIZE), .ASIZE(ASIZE), .NREQ(NREQ),
    .MAX_BURST(MAX_BURST), .AF_LEVEL(AF_LEVEL)
  ) dut (
    .wclk (wclk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: who owns the write port, beats in this burst, last owner
  int owner = -1;
  int nb    = 0;
  int lastp = NREQ - 1;
  bit chk_en = 1'b0;

  logic [NREQ-1:0] obs_grant;
  logic [NREQ-1:0] obs_rdy;
  logic            obs_wen;
  logic            obs_busy;
  logic [NREQ-1:0] prev_grant = '0;
  int beats   = 0;
  int cur_len = 0;
  int gnt_log[$];
  int len_log[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: sample outputs mid low phase, compare, then advance the model on the edge
  task automatic cycle();
    int eg, er, ew, ed, eb;
    #2;
    obs_grant = bus.grant;
    obs_rdy   = bus.req_ready;
    obs_wen   = bus.w_en;
    obs_busy  = bus.busy;
    eg = (owner >= 0) ? (1 << owner) : 0;
    eb = (owner >= 0) ? 1 : 0;
    er = (rst_n && owner >= 0 && !bus.w_full) ? eg : 0;
    ew = (rst_n && owner >= 0 && bus.req_valid[owner] && !bus.w_full) ? 1 : 0;
    ed = (rst_n && owner >= 0) ? int'((bus.req_data >> (owner * DSIZE)) & ((1 << DSIZE) - 1)) : 0;
    if (chk_en) begin
      chk("grant", 32'(bus.grant), eg);
      chk("busy", 32'(bus.busy), eb);
      chk("req_ready", 32'(bus.req_ready), er);
      chk("w_en", 32'(bus.w_en), ew);
      chk("wdata", 32'(bus.wdata), ed);
    end
    if (bus.w_en) beats++;
    if (bus.grant != 0 && prev_grant == 0) gnt_log.push_back($clog2(bus.grant));
    if (bus.grant != 0 && bus.w_en) cur_len++;
    if (bus.grant == 0 && prev_grant != 0) begin
      len_log.push_back(cur_len);
      cur_len = 0;
    end
    prev_grant = bus.grant;
    @(posedge wclk);
    if (!rst_n) begin
      owner = -1; nb = 0; lastp = NREQ - 1;
    end else if (owner < 0) begin
      if (int'(bus.wuse) < AF_LEVEL) begin
        for (int k = 1; k <= NREQ; k++) begin
          if (bus.req_valid[(lastp + k) % NREQ]) begin
            owner = (lastp + k) % NREQ;
            nb = 0;
            break;
          end
        end
      end
    end else if (bus.req_valid[owner] && !bus.w_full) begin
      nb++;
      if (bus.req_last[owner] || nb == MAX_BURST) begin
        lastp = owner; owner = -1; nb = 0;
      end
    end
    @(negedge wclk);
  endtask

  // Let the current owner finish with a last beat, then leave the arbiter idle
  task automatic drain();
    bus.w_full = 1'b0;
    bus.wuse   = '0;
    for (int c = 0; c < 60 && bus.grant != 0; c++) begin
      bus.req_valid = bus.grant;
      bus.req_last  = bus.grant;
      bus.req_data  = $urandom;
      cycle();
    end
    bus.req_valid = '0;
    bus.req_last  = '0;
    cycle();
    chk("drain_idle", 32'(bus.grant), 0);
  endtask

  task automatic clear_logs();
    gnt_log.delete();
    len_log.delete();
    cur_len = 0;
  endtask

  initial begin
    int c;
    rst_n = 1'b0;
    bus.req_valid = '0;
    bus.req_last  = '0;
    bus.req_data  = '0;
    bus.w_full    = 1'b0;
    bus.wuse      = '0;
    @(negedge wclk);
    cycle();
    chk_en = 1'b1;
    cycle();
    cycle();
    rst_n = 1'b1;

    // Test 1: all requesters valid, single-beat packets
    clear_logs();
    for (c = 0; c < 20 && gnt_log.size() < 5; c++) begin
      bus.req_valid = 4'b1111;
      bus.req_last  = 4'b1111;
      bus.req_data  = $urandom;
      cycle();
    end
    for (int k = 0; k < 5; k++)
      chk($sformatf("t1_order%0d", k), (gnt_log.size() > k) ? gnt_log[k] : -1, k % NREQ);
    drain();

    // Test 2: requester 2 streams 40 beats, last only on the final one
    clear_logs();
    beats = 0;
    for (c = 0; c < 200 && beats < 40; c++) begin
      bus.req_valid = (beats < 40) ? 4'b0100 : 4'b0000;
      bus.req_last  = (beats == 39) ? 4'b0100 : 4'b0000;
      bus.req_data  = $urandom;
      cycle();
    end
    chk("t2_beats", beats, 40);
    bus.req_valid = '0;
    bus.req_last  = '0;
    cycle();
    cycle();
    chk("t2_nbursts", len_log.size(), 3);
    chk("t2_len0", (len_log.size() > 0) ? len_log[0] : -1, 16);
    chk("t2_len1", (len_log.size() > 1) ? len_log[1] : -1, 16);
    chk("t2_len2", (len_log.size() > 2) ? len_log[2] : -1, 8);
    chk("t2_regrant", (gnt_log.size() > 2) ? gnt_log[2] : -1, 2);

    // Test 3: 10-beat packet from requester 1 with a 5-cycle w_full stall
    drain();
    clear_logs();
    beats = 0;
    for (c = 0; c < 100 && beats < 10; c++) begin
      bus.req_valid = 4'b0010;
      bus.req_last  = (beats == 9) ? 4'b0010 : 4'b0000;
      bus.w_full    = (c >= 4 && c < 9);
      bus.req_data  = $urandom;
      cycle();
      if (c >= 4 && c < 9) begin
        chk("t3_stall_wen", 32'(obs_wen), 0);
        chk("t3_stall_rdy", 32'(obs_rdy), 0);
        chk("t3_stall_grant", 32'(obs_grant), 32'h2);
      end
    end
    bus.w_full    = 1'b0;
    bus.req_valid = '0;
    bus.req_last  = '0;
    cycle();
    chk("t3_len", (len_log.size() > 0) ? len_log[0] : -1, 10);

    // Test 4: almost-full blocks new grants
    drain();
    bus.wuse      = ASIZE'(1000);
    bus.req_valid = 4'b0001;
    bus.req_last  = 4'b0001;
    for (int k = 0; k < 4; k++) begin
      bus.req_data = $urandom;
      cycle();
      chk("t4_af_busy", 32'(obs_busy), 0);
      chk("t4_af_grant", 32'(obs_grant), 0);
    end
    bus.wuse = ASIZE'(999);
    cycle();
    cycle();
    chk("t4_grant_after", 32'(obs_grant), 32'h1);
    drain();

    // Test 5: after requester 3 finishes, requester 1 wins over requester 3
    for (c = 0; c < 20 && !(obs_wen && obs_grant == 4'b1000); c++) begin
      bus.req_valid = 4'b1000;
      bus.req_last  = 4'b1000;
      bus.req_data  = $urandom;
      cycle();
    end
    clear_logs();
    bus.req_valid = 4'b1010;
    bus.req_last  = 4'b1010;
    for (int k = 0; k < 3; k++) begin
      bus.req_data = $urandom;
      cycle();
    end
    chk("t5_wrap", (gnt_log.size() > 0) ? gnt_log[0] : -1, 1);
    drain();

    // Test 6: reset in the middle of a burst
    beats = 0;
    for (c = 0; c < 50 && beats < 5; c++) begin
      bus.req_valid = 4'b0100;
      bus.req_last  = 4'b0000;
      bus.req_data  = $urandom;
      cycle();
    end
    rst_n = 1'b0;
    cycle();
    chk("t6_rst_wen", 32'(obs_wen), 0);
    #2;
    chk("t6_rst_grant", 32'(bus.grant), 0);
    chk("t6_rst_busy", 32'(bus.busy), 0);
    @(negedge wclk);
    rst_n = 1'b1;
    clear_logs();
    bus.req_valid = 4'b1111;
    bus.req_last  = 4'b1111;
    cycle();
    cycle();
    chk("t6_prio", (gnt_log.size() > 0) ? gnt_log[0] : -1, 0);
    drain();

    // Randomized traffic against the model
    for (int k = 0; k < 600; k++) begin
      bus.req_valid = NREQ'($urandom_range(0, (1 << NREQ) - 1));
      bus.req_last  = ($urandom_range(0, 3) == 0) ? NREQ'($urandom) : '0;
      bus.req_data  = $urandom;
      bus.w_full    = ($urandom_range(0, 4) == 0);
      bus.wuse      = ($urandom_range(0, 9) == 0) ? ASIZE'($urandom_range(1000, 1023))
                                                  : ASIZE'($urandom_range(0, 999));
      rst_n         = ($urandom_range(0, 99) != 0);
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
